// File: rtl/shake_pad_seq_if.sv
// Byte-stream input and padded-block output handshakes of the SHAKE256 absorb sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface shake_pad_seq_if #(
  parameter int RATE_BITS = 1088
);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic                 in_last;
  logic                 in_empty;
  logic                 blk_valid;
  logic                 blk_ready;
  logic [RATE_BITS-1:0] blk_data;

  modport master (
    output in_valid, in_data, in_last, in_empty, blk_ready,
    input  in_ready, blk_valid, blk_data
  );

  modport slave (
    input  in_valid, in_data, in_last, in_empty, blk_ready,
    output in_ready, blk_valid, blk_data
  );
endinterface

// File: rtl/shake_pad_seq.sv
// Single-block SHAKE256 absorb sequencer: clears the padder, feeds message bytes LSB-first,
// appends the domain separator, sets the final pad bit and hands the block downstream.
module shake_pad_seq #(
  parameter int         RATE_BITS   = 1088,
  parameter int         MAX_BYTES   = 135,
  parameter logic [7:0] DOMAIN_SEP  = 8'h1F,
  parameter int         WDOG_CYCLES = 2047
) (
  input  logic                 clk,
  input  logic                 reset,
  shake_pad_seq_if.slave       bus,
  output logic                 pad_clear,
  output logic                 pad_enable,
  output logic                 pad_serial_in,
  output logic                 pad_end,
  output logic                 pad_ds_enable,
  output logic [7:0]           pad_ds,
  input  logic [RATE_BITS-1:0] pad_message,
  input  logic                 pad_valid,
  input  logic                 pad_error,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 clear_err,
  output logic [7:0]           byte_count
);

  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_SHIFT, S_END, S_WAIT_PAD, S_ISSUE, S_ERROR
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           shreg;
  logic                 last_q;
  logic [2:0]           bit_cnt;
  logic [WDOG_W-1:0]    wdog;
  logic [RATE_BITS-1:0] blk_q;
  logic                 accept;
  logic                 empty_last;
  logic                 overflow;
  logic                 load_byte;

  assign pad_ds       = DOMAIN_SEP;
  assign bus.blk_data = blk_q;
  assign accept       = (state_q == S_LOAD) && bus.in_valid;
  assign empty_last   = bus.in_last && bus.in_empty;
  assign overflow     = (byte_count == 8'(MAX_BYTES));
  assign load_byte    = accept && !empty_last && !overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // The padder is held cleared whenever no message is in flight, so a reset or error
  // can never leave stale bits behind for the next block.
  always_comb begin
    state_d         = state_q;
    pad_clear       = 1'b0;
    pad_enable      = 1'b0;
    pad_serial_in   = 1'b0;
    pad_end         = 1'b0;
    pad_ds_enable   = 1'b0;
    bus.in_ready    = 1'b0;
    bus.blk_valid   = 1'b0;
    done            = 1'b0;
    busy            = 1'b1;
    case (state_q)
      S_IDLE: begin
        pad_clear = 1'b1;
        busy      = 1'b0;
        if (bus.in_valid) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        pad_clear = 1'b1;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (accept) begin
          if (empty_last)    state_d = S_END;
          else if (overflow) state_d = S_ERROR;
          else               state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        pad_enable    = 1'b1;
        pad_serial_in = shreg[0];
        if (bit_cnt == 3'd7) state_d = last_q ? S_END : S_LOAD;
      end
      S_END: begin
        pad_enable    = 1'b1;
        pad_end       = 1'b1;
        pad_ds_enable = 1'b1;
        state_d       = S_WAIT_PAD;
      end
      S_WAIT_PAD: begin
        pad_enable = 1'b1;
        if (pad_error)                                 state_d = S_ERROR;
        else if (pad_valid)                            state_d = S_ISSUE;
        else if (wdog == WDOG_W'(WDOG_CYCLES - 1))     state_d = S_ERROR;
      end
      S_ISSUE: begin
        bus.blk_valid = 1'b1;
        if (bus.blk_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        pad_clear = 1'b1;
        busy      = 1'b0;
        if (clear_err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // err simply mirrors residence in ERROR, which is left only through clear_err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      last_q     <= 1'b0;
      bit_cnt    <= '0;
      wdog       <= '0;
      blk_q      <= '0;
      byte_count <= '0;
      err        <= 1'b0;
    end else begin
      err <= (state_d == S_ERROR);
      case (state_q)
        S_CLEAR: byte_count <= '0;
        S_LOAD: begin
          if (load_byte) begin
            shreg      <= bus.in_data;
            last_q     <= bus.in_last;
            byte_count <= byte_count + 8'd1;
            bit_cnt    <= '0;
          end
        end
        S_SHIFT: begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        S_END: wdog <= '0;
        S_WAIT_PAD: begin
          wdog <= wdog + 1'b1;
          if (pad_valid && !pad_error) begin
            blk_q                <= pad_message;
            blk_q[RATE_BITS-1]   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shake_pad_seq.sv
// Directed bench for shake_pad_seq with a behavioural bit-serial padder model.
module tb_shake_pad_seq;
  localparam int RB = 1088;

  logic          clk;
  logic          reset;
  logic          pad_clear, pad_enable, pad_serial_in, pad_end, pad_ds_enable;
  logic [7:0]    pad_ds;
  logic [RB-1:0] pad_message;
  logic          pad_valid;
  logic          pad_error;
  logic          busy, done, err, clear_err;
  logic [7:0]    byte_count;

  int checks = 0;
  int passes = 0;

  shake_pad_seq_if #(.RATE_BITS(RB)) bus ();

  shake_pad_seq dut (
    .clk(clk), .reset(reset), .bus(bus),
    .pad_clear(pad_clear), .pad_enable(pad_enable), .pad_serial_in(pad_serial_in),
    .pad_end(pad_end), .pad_ds_enable(pad_ds_enable), .pad_ds(pad_ds),
    .pad_message(pad_message), .pad_valid(pad_valid), .pad_error(pad_error),
    .busy(busy), .done(done), .err(err), .clear_err(clear_err), .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Padder model: collects serial bits in order, appends the domain byte on pad_end,
  // then raises valid after a short delay unless told to hang.
  logic [RB-1:0] pm_bits;
  int            pm_idx;
  logic          pm_armed;
  int            pm_cnt;
  logic          pad_hang;

  assign pad_message = pm_bits;

  always @(posedge clk or posedge reset) begin
    if (reset || pad_clear) begin
      pm_bits   <= '0;
      pm_idx    <= 0;
      pm_armed  <= 1'b0;
      pm_cnt    <= 0;
      pad_valid <= 1'b0;
    end else begin
      if (pad_enable) begin
        if (pad_end) begin
          if (pad_ds_enable) pm_bits[pm_idx +: 8] <= pad_ds;
          pm_armed <= 1'b1;
          pm_cnt   <= 4;
        end else if (!pm_armed) begin
          pm_bits[pm_idx] <= pad_serial_in;
          pm_idx          <= pm_idx + 1;
        end
      end
      if (pm_armed && !pad_valid && !pad_hang) begin
        if (pm_cnt == 0) pad_valid <= 1'b1;
        else             pm_cnt <= pm_cnt - 1;
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input logic [7:0] data, input logic last, input logic empty,
                               input int shift_samples, output int ready_seen,
                               output int enable_seen, output bit timed_out);
    int n = 0;
    ready_seen    = 0;
    enable_seen   = 0;
    timed_out     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = data;
    bus.in_last   = last;
    bus.in_empty  = empty;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      timed_out    = 1'b1;
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < shift_samples; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.in_ready === 1'b1) ready_seen++;
      if (pad_enable === 1'b1)   enable_seen++;
    end
  endtask

  task automatic waitBlock(output int cycles, output bit timed_out);
    cycles = 0;
    while (bus.blk_valid !== 1'b1 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    timed_out = (cycles >= 3000);
  endtask

  task automatic releaseBlock(output int pulses);
    pulses        = 0;
    bus.blk_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    bus.blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (pad_clear !== 1'b1) $display("[TB] FAIL reset_pad_clear got %b want 1", pad_clear); else passes++;
    checks++; if ({bus.in_ready, bus.blk_valid, busy, done, err, pad_enable, pad_end, pad_ds_enable} !== 8'h00)
      $display("[TB] FAIL reset_outputs got %b want 00000000", {bus.in_ready, bus.blk_valid, busy, done, err, pad_enable, pad_end, pad_ds_enable}); else passes++;
    checks++; if (byte_count !== 8'd0 || bus.blk_data !== '0)
      $display("[TB] FAIL reset_counts byte_count %0d blk_low %h want 0", byte_count, bus.blk_data[63:0]); else passes++;
    checks++; if (pad_ds !== 8'h1F) $display("[TB] FAIL reset_pad_ds got %h want 1f", pad_ds); else passes++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_empty();
    logic [RB-1:0] exp = '0;
    int rs, es, cyc, pulses;
    bit to1, to2;
    exp[7:0]  = 8'h1F;
    exp[RB-1] = 1'b1;
    applyStimulus(8'h00, 1'b1, 1'b1, 0, rs, es, to1);
    waitBlock(cyc, to2);
    checks++; if (to1 || to2) $display("[TB] FAIL empty_timeout got %b%b want 00", to1, to2); else passes++;
    checks++; if (cyc + 1 > 8 + 1 + RB + 3) $display("[TB] FAIL empty_latency got %0d want <= %0d", cyc + 1, 8 + 1 + RB + 3); else passes++;
    checks++; if (bus.blk_data !== exp)
      $display("[TB] FAIL empty_block got top %h low %h want top %h low %h", bus.blk_data[RB-1:RB-8], bus.blk_data[127:0], exp[RB-1:RB-8], exp[127:0]); else passes++;
    checks++; if (byte_count !== 8'd0) $display("[TB] FAIL empty_byte_count got %0d want 0", byte_count); else passes++;
    releaseBlock(pulses);
    checks++; if (pulses !== 1) $display("[TB] FAIL empty_done_pulses got %0d want 1", pulses); else passes++;
    checks++; if (bus.blk_valid !== 1'b0) $display("[TB] FAIL empty_blk_valid_after got %b want 0", bus.blk_valid); else passes++;
  endtask

  task automatic test_abc(input string tag);
    logic [7:0]    msg [3] = '{8'h61, 8'h62, 8'h63};
    logic [RB-1:0] exp = '0;
    int rs, es, rs_sum = 0, es_sum = 0, cyc, pulses;
    bit to, any_to = 1'b0;
    exp[31:0] = 32'h1F636261;
    exp[RB-1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(msg[k], k == 2, 1'b0, 8, rs, es, to);
      rs_sum += rs;
      es_sum += es;
      any_to |= to;
    end
    waitBlock(cyc, to);
    any_to |= to;
    checks++; if (any_to) $display("[TB] FAIL %s_timeout got 1 want 0", tag); else passes++;
    checks++; if (rs_sum !== 0) $display("[TB] FAIL %s_ready_in_shift got %0d want 0", tag, rs_sum); else passes++;
    checks++; if (es_sum !== 24) $display("[TB] FAIL %s_enable_in_shift got %0d want 24", tag, es_sum); else passes++;
    checks++; if (bus.blk_data !== exp)
      $display("[TB] FAIL %s_block got top %h low %h want top %h low %h", tag, bus.blk_data[RB-1:RB-8], bus.blk_data[127:0], exp[RB-1:RB-8], exp[127:0]); else passes++;
    checks++; if (byte_count !== 8'd3) $display("[TB] FAIL %s_byte_count got %0d want 3", tag, byte_count); else passes++;
    releaseBlock(pulses);
    checks++; if (pulses !== 1) $display("[TB] FAIL %s_done_pulses got %0d want 1", tag, pulses); else passes++;
  endtask

  task automatic test_max_message();
    logic [RB-1:0] exp = '0;
    int rs, es, cyc, pulses;
    bit to, any_to = 1'b0;
    for (int k = 0; k < 135; k++) exp[8*k +: 8] = 8'hA5;
    exp[1087:1080] = 8'h9F;
    for (int k = 0; k < 135; k++) begin
      applyStimulus(8'hA5, k == 134, 1'b0, 8, rs, es, to);
      any_to |= to;
    end
    waitBlock(cyc, to);
    any_to |= to;
    checks++; if (any_to) $display("[TB] FAIL max_timeout got 1 want 0"); else passes++;
    checks++; if (bus.blk_data !== exp)
      $display("[TB] FAIL max_block got top %h low %h want top %h low %h", bus.blk_data[RB-1:RB-16], bus.blk_data[63:0], exp[RB-1:RB-16], exp[63:0]); else passes++;
    checks++; if (err !== 1'b0 || byte_count !== 8'd135)
      $display("[TB] FAIL max_status err %b byte_count %0d want 0 135", err, byte_count); else passes++;
    releaseBlock(pulses);
  endtask

  task automatic test_overflow();
    int rs, es, seen_valid = 0;
    bit to, any_to = 1'b0;
    for (int k = 0; k < 135; k++) begin
      applyStimulus(8'h3C, 1'b0, 1'b0, 8, rs, es, to);
      any_to |= to;
    end
    applyStimulus(8'h11, 1'b1, 1'b0, 0, rs, es, to);
    any_to |= to;
    checks++; if (any_to) $display("[TB] FAIL overflow_timeout got 1 want 0"); else passes++;
    checks++; if ({err, bus.in_ready, pad_clear, busy, pad_enable} !== 5'b10100)
      $display("[TB] FAIL overflow_state got %b want 10100", {err, bus.in_ready, pad_clear, busy, pad_enable}); else passes++;
    checks++; if (byte_count !== 8'd135) $display("[TB] FAIL overflow_byte_count got %0d want 135", byte_count); else passes++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.blk_valid === 1'b1) seen_valid++;
    end
    checks++; if (seen_valid !== 0 || err !== 1'b1)
      $display("[TB] FAIL overflow_sticky blk_valid_cycles %0d err %b want 0 1", seen_valid, err); else passes++;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    checks++; if (err !== 1'b0 || busy !== 1'b0 || pad_clear !== 1'b1)
      $display("[TB] FAIL overflow_clear err %b busy %b pad_clear %b want 0 0 1", err, busy, pad_clear); else passes++;
    test_abc("abc_after_err");
  endtask

  task automatic test_back_pressure();
    logic [RB-1:0] exp = '0;
    int rs, es, cyc, pulses, stable_bad = 0, early_done = 0;
    bit to1, to2;
    exp[15:0] = 16'h1F5A;
    exp[RB-1] = 1'b1;
    applyStimulus(8'h5A, 1'b1, 1'b0, 8, rs, es, to1);
    waitBlock(cyc, to2);
    checks++; if (to1 || to2) $display("[TB] FAIL bp_timeout got %b%b want 00", to1, to2); else passes++;
    for (int i = 0; i < 5; i++) begin
      if (bus.blk_valid !== 1'b1 || bus.blk_data !== exp) stable_bad++;
      if (done === 1'b1) early_done++;
      @(negedge clk);
    end
    checks++; if (stable_bad !== 0) $display("[TB] FAIL bp_hold_stable got %0d bad cycles want 0", stable_bad); else passes++;
    checks++; if (early_done !== 0) $display("[TB] FAIL bp_early_done got %0d want 0", early_done); else passes++;
    releaseBlock(pulses);
    checks++; if (pulses !== 1) $display("[TB] FAIL bp_done_pulses got %0d want 1", pulses); else passes++;
    checks++; if (bus.blk_data !== exp) $display("[TB] FAIL bp_data_retained got low %h want %h", bus.blk_data[63:0], exp[63:0]); else passes++;
  endtask

  task automatic test_pad_error();
    int rs, es, seen_valid = 0;
    bit to;
    pad_hang = 1'b1;
    applyStimulus(8'h77, 1'b1, 1'b0, 8, rs, es, to);
    @(negedge clk);
    checks++; if (to || pad_end !== 1'b1 || pad_ds_enable !== 1'b1)
      $display("[TB] FAIL perr_end_phase to %b pad_end %b ds_en %b want 0 1 1", to, pad_end, pad_ds_enable); else passes++;
    @(negedge clk);
    checks++; if (pad_end !== 1'b0 || pad_enable !== 1'b1 || busy !== 1'b1)
      $display("[TB] FAIL perr_wait_phase pad_end %b pad_enable %b busy %b want 0 1 1", pad_end, pad_enable, busy); else passes++;
    pad_error = 1'b1;
    @(negedge clk);
    pad_error = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.blk_valid === 1'b1) seen_valid++;
      @(negedge clk);
    end
    checks++; if (err !== 1'b1 || seen_valid !== 0)
      $display("[TB] FAIL perr_result err %b blk_valid_cycles %0d want 1 0", err, seen_valid); else passes++;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    pad_hang  = 1'b0;
  endtask

  task automatic test_watchdog();
    int rs, es, cnt = 0;
    bit to;
    pad_hang = 1'b1;
    applyStimulus(8'h42, 1'b1, 1'b0, 8, rs, es, to);
    while (err !== 1'b1 && cnt < 2300) begin
      @(negedge clk);
      cnt++;
    end
    checks++; if (to || cnt < 2047 || cnt > 2050)
      $display("[TB] FAIL watchdog_delay got %0d cycles want 2047..2050", cnt); else passes++;
    checks++; if (bus.blk_valid !== 1'b0 || pad_clear !== 1'b1)
      $display("[TB] FAIL watchdog_state blk_valid %b pad_clear %b want 0 1", bus.blk_valid, pad_clear); else passes++;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    pad_hang  = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int rs, es, seen_valid = 0;
    bit to;
    applyStimulus(8'hC3, 1'b1, 1'b0, 3, rs, es, to);
    checks++; if (to || es !== 3) $display("[TB] FAIL rst_mid_in_shift to %b enable_cycles %0d want 0 3", to, es); else passes++;
    #1 reset = 1'b1;
    #1;
    checks++; if ({bus.in_ready, bus.blk_valid, pad_clear, pad_enable, busy} !== 5'b00100)
      $display("[TB] FAIL rst_mid_outputs got %b want 00100", {bus.in_ready, bus.blk_valid, pad_clear, pad_enable, busy}); else passes++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.blk_valid === 1'b1) seen_valid++;
    end
    checks++; if (seen_valid !== 0) $display("[TB] FAIL rst_mid_no_block got %0d want 0", seen_valid); else passes++;
  endtask

  initial begin
    reset         = 1'b1;
    clear_err     = 1'b0;
    pad_error     = 1'b0;
    pad_hang      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.in_empty  = 1'b0;
    bus.blk_ready = 1'b0;
    test_reset();
    test_empty();
    test_abc("abc");
    test_max_message();
    test_overflow();
    test_back_pressure();
    test_pad_error();
    test_watchdog();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/shake_pad_seq.md
Name: shake_pad_seq

Overview:
- Single-block absorb sequencer for the SHAKE256 padder (136-byte rate, 1088-bit message, bit-serial input with domain-separation path).
- Accepts a byte stream over a valid/ready handshake and clears the padder before each message.
- Serialises bytes LSB-first into the padder, then triggers the domain-separator append and waits for the padded block.
- Sets the final pad bit (1087) and hands the 1088-bit block to the permutation stage over a valid/ready handshake.

Parameters:
- RATE_BITS, 1088, rate block width in bits.
- MAX_BYTES, 135, largest message accepted (RATE_BITS/8 - 1, leaving room for the domain byte).
- DOMAIN_SEP, 8'h1F, SHAKE domain-separator byte driven to the padder.
- WDOG_CYCLES, 2047, maximum cycles to wait for padder completion.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  sequencer can accept a byte.
- in_data  in  8  message byte.
- in_last  in  1  byte is the final one of the message.
- in_empty  in  1  qualifies in_last: zero-length message, in_data ignored.
- pad_clear  out  1  drives padder reset.
- pad_enable  out  1  padder enable.
- pad_serial_in  out  1  padder serial data.
- pad_end  out  1  padder serial_end_signal.
- pad_ds_enable  out  1  padder domain_sep_enable.
- pad_ds  out  8  padder domain_sep; constant DOMAIN_SEP.
- pad_message  in  1088  padder message.
- pad_valid  in  1  padder valid_output.
- pad_error  in  1  padder error_flag.
- blk_valid  out  1  padded block available.
- blk_ready  in  1  permutation accepts block.
- blk_data  out  1088  padded block.
- busy  out  1  high in any state except IDLE and ERROR.
- done  out  1  one-cycle pulse on block handoff.
- err  out  1  sticky error.
- clear_err  in  1  synchronous error clear.
- byte_count  out  8  bytes accepted in the current message.

Behaviour:
- Reset values:
  - pad_clear=1; all other outputs 0 (in_ready, pad_*, blk_valid, blk_data, busy, done, err, byte_count).
  - pad_ds is always DOMAIN_SEP.
  - State=IDLE.
  - Reset mid-operation aborts the message; no partial block is ever issued.
- State IDLE:
  - pad_clear=1, in_ready=0.
  - On in_valid, go to CLEAR; the byte is not consumed in IDLE.
- State CLEAR:
  - pad_clear=1 for exactly one cycle, byte_count<=0, then go to LOAD.
- State LOAD:
  - in_ready=1, pad_enable=0.
  - On handshake with in_last&in_empty: go to END; byte_count unchanged.
  - Otherwise, if byte_count==MAX_BYTES: err<=1, go to ERROR (byte consumed).
  - Otherwise: latch in_data into an 8-bit shift register, latch in_last, byte_count+=1, bit counter<=0, go to SHIFT.
- State SHIFT (8 cycles):
  - pad_enable=1, pad_serial_in=shreg[0]; shift right each cycle.
  - After the 8th bit: go to END if the latched last flag is set, else go to LOAD.
  - in_ready=0 throughout.
- State END (1 cycle):
  - pad_enable=1, pad_end=1, pad_ds_enable=1.
  - Go to WAIT_PAD.
- State WAIT_PAD:
  - pad_enable=1; pad_end=0 and pad_ds_enable=0.
  - Watchdog counts cycles.
  - pad_error=1 → ERROR.
  - pad_valid=1 → capture blk_data = pad_message with bit 1087 forced to 1, go to ISSUE.
  - Watchdog reaching WDOG_CYCLES → ERROR.
  - pad_error takes priority over pad_valid in the same cycle.
- State ISSUE:
  - blk_valid=1; blk_data held stable until blk_ready.
  - On blk_valid&blk_ready: done=1 for one cycle, blk_valid<=0, go to IDLE.
  - blk_data retains its value until the next capture.
- State ERROR:
  - err=1; in_ready=0, pad_enable=0, pad_clear=1.
  - clear_err → err<=0, go to IDLE.
- Ordering and latency:
  - Bit order: message byte k occupies blk_data[8k+7:8k]; byte 0 bit 0 goes out first.
  - Latency from last-byte handshake to blk_valid: at most 8 + 1 + (RATE_BITS - 8N) + 3 cycles for an N-byte message.

Test Plan:
- Empty message (in_last=1, in_empty=1) → blk_data[7:0]=8'h1F, bit 1087=1, all other bits 0; done pulses once; byte_count=0.
- "abc" (8'h61, 8'h62, 8'h63, last on 8'h63) → blk_data[31:0]=32'h1F636261, bit 1087=1, rest 0; in_ready low during each 8-cycle SHIFT.
- 135 bytes of 8'hA5 → bytes 0..134 = 8'hA5, byte 135 = 8'h9F (1F | bit 1087), err=0.
- 136th byte offered → err=1, state ERROR, no blk_valid; clear_err → IDLE, and a following "abc" message completes correctly.
- blk_ready held low for 5 cycles in ISSUE → blk_valid stays 1 and blk_data is stable; done pulses exactly in the handshake cycle.
- Fault and reset cases:
  - pad_error forced high in WAIT_PAD → err=1, no block issued.
  - Reset asserted during SHIFT → in_ready=0, blk_valid=0, pad_clear=1 immediately.
